timer_display: RTL and testbench

TIMER_DISPLAY -- requirements
Module: timer_display

---
 rtl/timer_display_if.sv | 30 +++
 rtl/timer_display.sv | 159 +++++++++++++++
 tb/tb_timer_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/timer_display_if.sv
// Bundle of the timer_display data/handshake signals.
//   value_in   : countdown in milliseconds (IN_WIDTH bits, unsigned)
//   sample_req : single-cycle request for an immediate conversion
//   busy       : conversion in progress
//   bcd_out    : five BCD digits, [3:0] ms units .. [19:16] tens of seconds
//   bcd_valid  : one-cycle pulse when bcd_out updates
//   hex2/1/0   : active-low 7-segment (gfedcba) for tens-of-s, s, tenths
// Modports: master drives value_in/sample_req, slave is the converter.
interface timer_display_if #(
  parameter int IN_WIDTH = 15
);
  logic [IN_WIDTH-1:0] value_in;
  logic                sample_req;
  logic                busy;
  logic [19:0]         bcd_out;
  logic                bcd_valid;
  logic [6:0]          hex2;
  logic [6:0]          hex1;
  logic [6:0]          hex0;

  modport master (
    output value_in, sample_req,
    input  busy, bcd_out, bcd_valid, hex2, hex1, hex0
  );

  modport slave (
    input  value_in, sample_req,
    output busy, bcd_out, bcd_valid, hex2, hex1, hex0
  );
endinterface

// File: rtl/timer_display.sv
// timer_display: periodically (every REFRESH_CLKS clocks) or on sample_req,
// captures a millisecond countdown and converts it to five BCD digits with a
// serial double-dabble (one bit per clock), then drives three 7-segment
// displays (tens of seconds, seconds, tenths).
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   io  : timer_display_if.slave (value_in, sample_req, busy, bcd_out,
//         bcd_valid, hex2, hex1, hex0)
// Parameters: IN_WIDTH (1..16), REFRESH_CLKS (> IN_WIDTH+1).
// Build option: define TIMER_DISPLAY_BLANK_EN to blank hex2 when its digit
// is 0 (leading-zero blanking, also the reset value).
module timer_display #(
  parameter int IN_WIDTH     = 15,
  parameter int REFRESH_CLKS = 50000
) (
  input  logic           clk,
  input  logic           rst,
  timer_display_if.slave io
);

  localparam int CNT_W = (REFRESH_CLKS > 1) ? $clog2(REFRESH_CLKS) : 1;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef TIMER_DISPLAY_BLANK_EN
  localparam logic [6:0] HEX2_RST = SEG_BLANK;
`else
  localparam logic [6:0] HEX2_RST = SEG_ZERO;
`endif

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    refresh_cnt;
  logic                tick;
  logic                accept;
  logic [IN_WIDTH-1:0] cap;
  logic [19:0]         scratch;
  logic [19:0]         adj;
  logic [4:0]          iter;
  logic [19:0]         bcd_q;
  logic                valid_q;
  logic [6:0]          hex2_q, hex1_q, hex0_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] hex2_enc(input logic [3:0] d);
`ifdef TIMER_DISPLAY_BLANK_EN
    return (d == 4'd0) ? SEG_BLANK : seg7(d);
`else
    return seg7(d);
`endif
  endfunction

  assign tick = (refresh_cnt == CNT_W'(REFRESH_CLKS - 1));

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick || io.sample_req) begin
          accept  = 1'b1;
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        if (iter == 5'(IN_WIDTH - 1))
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      cap         <= '0;
      scratch     <= '0;
      iter        <= '0;
      bcd_q       <= '0;
      valid_q     <= 1'b0;
      hex2_q      <= HEX2_RST;
      hex1_q      <= SEG_ZERO;
      hex0_q      <= SEG_ZERO;
    end else begin
      // A tick wraps the counter anyway, so a coinciding tick and
      // sample_req both end up restarting it from zero.
      if ((accept && io.sample_req) || tick)
        refresh_cnt <= '0;
      else
        refresh_cnt <= refresh_cnt + CNT_W'(1);

      valid_q <= (state == DONE);

      unique case (state)
        IDLE: begin
          if (accept) begin
            cap     <= io.value_in;
            scratch <= '0;
            iter    <= '0;
          end
        end
        CONVERT: begin
          scratch <= {adj[18:0], cap[IN_WIDTH-1]};
          cap     <= cap << 1;
          iter    <= iter + 5'd1;
        end
        DONE:    bcd_q <= scratch;
        default: ;
      endcase

      hex2_q <= hex2_enc(bcd_q[19:16]);
      hex1_q <= seg7(bcd_q[15:12]);
      hex0_q <= seg7(bcd_q[11:8]);
    end
  end

  assign io.busy      = (state != IDLE);
  assign io.bcd_out   = bcd_q;
  assign io.bcd_valid = valid_q;
  assign io.hex2      = hex2_q;
  assign io.hex1      = hex1_q;
  assign io.hex0      = hex0_q;

endmodule

// File: tb/tb_timer_display.sv
module tb_timer_display;
  localparam int W = 15;
  localparam int R = 20;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  timer_display_if #(.IN_WIDTH(W)) io ();

  timer_display #(.IN_WIDTH(W), .REFRESH_CLKS(R)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] bcd;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   bl     = 0;   // negedges for which busy is still expected high
  int   cnt    = 0;   // expected refresh counter value
  logic [W-1:0] cur_v = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] seg_hex2(input logic [3:0] d);
`ifdef TIMER_DISPLAY_BLANK_EN
    if (d == 4'd0) return 7'b1111111;
`endif
    return seg(d);
  endfunction

  // One clock of stimulus plus the reference model of what the edge does.
  task automatic step(input logic [W-1:0] v, input logic req);
    logic idle, tk;
    @(negedge clk);
    chk("busy", 32'(io.busy), 32'(bl > 0));
    cur_v         = v;
    io.value_in   = v;
    io.sample_req = req;
    idle = (bl == 0);
    tk   = (cnt == R - 1);
    if (!idle) bl--;
    else if (req || tk) begin
      q.push_back('{bcd: to_bcd(int'(v)), cyc: cyc + W + 2});
      bl = W + 1;
    end
    if ((idle && req) || tk) cnt = 0;
    else cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    io.sample_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bl  = 0;
    cnt = 0;
    q.delete();
    chk("rst_bcd_out", 32'(io.bcd_out), 32'h0);
    chk("rst_busy", 32'(io.busy), 32'h0);
    chk("rst_valid", 32'(io.bcd_valid), 32'h0);
    chk("rst_hex0", 32'(io.hex0), 32'(7'b1000000));
    chk("rst_hex1", 32'(io.hex1), 32'(7'b1000000));
    chk("rst_hex2", 32'(io.hex2), 32'(seg_hex2(4'd0)));
  endtask

  task automatic wait_idle();
    while (bl != 0) step(cur_v, 1'b0);
  endtask

  // Monitor: every bcd_valid must match the oldest outstanding conversion,
  // at the predicted cycle, with the displays following one clock later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && io.bcd_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got bcd_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("bcd_out", 32'(io.bcd_out), 32'(e.bcd));
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
          @(negedge clk);
          chk("bcd_valid_pulse", 32'(io.bcd_valid), 32'h0);
          chk("hex0", 32'(io.hex0), 32'(seg(e.bcd[11:8])));
          chk("hex1", 32'(io.hex1), 32'(seg(e.bcd[15:12])));
          chk("hex2", 32'(io.hex2), 32'(seg_hex2(e.bcd[19:16])));
        end
      end
    end
  end

  initial begin
    int directed [4] = '{20999, 5432, 0, 32767};
    int v;
    rst = 1'b1;
    io.value_in = '0;
    io.sample_req = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed values, each followed by a request that lands mid-conversion.
    foreach (directed[i]) begin
      wait_idle();
      step(W'(directed[i]), 1'b1);
      step(W'(directed[i]), 1'b0);
      step(W'(directed[i]), 1'b0);
      step(W'(directed[i]), 1'b1);
      repeat (20) step(W'(directed[i]), 1'b0);
    end

    // Refresh-only conversions with a falling countdown.
    v = 30000;
    repeat (120) begin
      v = v - int'($urandom_range(1, 60));
      if (v < 0) v = 0;
      step(W'(v), 1'b0);
    end

    // Random values with sporadic requests.
    repeat (400) begin
      step(W'($urandom_range(0, 32767)), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a conversion, then a clean restart.
    wait_idle();
    step(W'(12345), 1'b1);
    repeat (7) step(W'(12345), 1'b0);
    do_reset();
    step(W'(9876), 1'b1);
    repeat (25) step(W'(9876), 1'b0);

    // Drain: every queued conversion must eventually be delivered.
    for (int i = 0; i < 200; i++) begin
      step(W'(0), 1'b0);
      #1;
      if (q.size() == 0) break;
    end
    chk("pending_conversions", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
